// File: rtl/frame_scan_controller_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the frame scan controller: FSM state encoding,
// the state enum type and the default counter widths.
// No ports (package).
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam int DEF_XW           = 4;
  localparam int DEF_YW           = 4;
  localparam int DEF_BLANK_CYCLES = 2;
  // Wide enough for BLANK_CYCLES up to 15.
  localparam int BLANK_CW         = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SCAN  = S_SCAN,
    ST_BLANK = S_BLANK,
    ST_DONE  = S_DONE
  } scan_state_t;

endpackage

// File: rtl/frame_scan_controller_if.sv
// -----------------------------------------------------------------------------
// frame_scan_controller_if
// Pixel-address stream between the scan controller (master) and the
// downstream consumer (slave).
//   pix_valid  master->slave  pix_x/pix_y hold a valid address
//   pix_ready  slave->master  consumer accepts the current pixel
//   pix_x      master->slave  current column
//   pix_y      master->slave  current row
//   line_end   master->slave  current pixel is the last of its line
//   frame_end  master->slave  current pixel is the last of the frame
// -----------------------------------------------------------------------------
interface frame_scan_controller_if #(
  parameter int XW = 4,
  parameter int YW = 4
);
  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          line_end;
  logic          frame_end;

  modport master (
    output pix_valid, pix_x, pix_y, line_end, frame_end,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, line_end, frame_end,
    output pix_ready
  );
endinterface

// File: rtl/frame_scan_controller_counter.sv
// -----------------------------------------------------------------------------
// scan_counter
// Wrapping up-counter 0..max used for both the column and the row index.
//   clk     clock
//   reset   synchronous active-high reset, count -> 0
//   clear   synchronous clear, count -> 0
//   enable  advance by one; wraps to 0 after reaching max
//   max     last value of the count range
//   count   current value
//   at_max  count equals max
// -----------------------------------------------------------------------------
module scan_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;

  assign count  = count_q;
  assign at_max = (count_q == max);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= at_max ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/frame_scan_controller.sv
// -----------------------------------------------------------------------------
// frame_scan_controller
// Walks a raster of (h_max+1) x (v_max+1) pixel addresses, advancing one
// pixel per accepted handshake on the pixel stream interface.
//   clk      clock
//   reset    synchronous active-high reset
//   start    begins a scan when sampled high in IDLE (latches h_max/v_max)
//   abort    ends the scan in progress, returns to IDLE, no done pulse
//   h_max    last column index
//   v_max    last row index
//   busy     high in every state except IDLE
//   done     one-cycle pulse after a completed frame
//   pix      pixel stream (master side)
// Build option: FRAME_SCAN_BLANK_EN adds a BLANK state of BLANK_CYCLES cycles
// after each non-final line. Without it a line wrap stays in SCAN.
// -----------------------------------------------------------------------------
module frame_scan_controller
  import scan_pkg::*;
#(
  parameter int XW           = DEF_XW,
  parameter int YW           = DEF_YW,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [XW-1:0]                   h_max,
  input  logic [YW-1:0]                   v_max,
  output logic                            busy,
  output logic                            done,
  frame_scan_controller_if.master         pix
);

  scan_state_t   state_q, state_d;
  logic [XW-1:0] hmax_q, hmax_d;
  logic [YW-1:0] vmax_q, vmax_d;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          x_at_max, y_at_max;
  logic          go, hs;

  // A start that coincides with abort is discarded.
  assign go = (state_q == ST_IDLE) && start && !abort;
  // abort wins over a simultaneous handshake.
  assign hs = (state_q == ST_SCAN) && pix.pix_ready && !abort;

  scan_counter #(.W(XW)) u_col (
    .clk    (clk),
    .reset  (reset),
    .clear  (go),
    .enable (hs),
    .max    (hmax_q),
    .count  (x_cnt),
    .at_max (x_at_max)
  );

  // Row advances on the column wrap; it holds at v_max on the final pixel.
  scan_counter #(.W(YW)) u_row (
    .clk    (clk),
    .reset  (reset),
    .clear  (go),
    .enable (hs && x_at_max && !y_at_max),
    .max    (vmax_q),
    .count  (y_cnt),
    .at_max (y_at_max)
  );

`ifdef FRAME_SCAN_BLANK_EN
  logic [BLANK_CW-1:0] blank_q, blank_d;
`endif

  always_comb begin
    state_d = state_q;
    hmax_d  = hmax_q;
    vmax_d  = vmax_q;
`ifdef FRAME_SCAN_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_SCAN;
          hmax_d  = h_max;
          vmax_d  = v_max;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pix.pix_ready && x_at_max) begin
          if (y_at_max) begin
            state_d = ST_DONE;
          end else begin
`ifdef FRAME_SCAN_BLANK_EN
            // Counter holds the number of blank cycles still to follow.
            state_d = ST_BLANK;
            blank_d = BLANK_CW'(BLANK_CYCLES - 1);
`endif
          end
        end
      end
`ifdef FRAME_SCAN_BLANK_EN
      ST_BLANK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (blank_q == '0) begin
          state_d = ST_SCAN;
        end else begin
          blank_d = blank_q - 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hmax_q  <= '0;
      vmax_q  <= '0;
`ifdef FRAME_SCAN_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hmax_q  <= hmax_d;
      vmax_q  <= vmax_d;
`ifdef FRAME_SCAN_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign pix.pix_valid = (state_q == ST_SCAN);
  assign pix.pix_x     = x_cnt;
  assign pix.pix_y     = y_cnt;
  assign pix.line_end  = pix.pix_valid && x_at_max;
  assign pix.frame_end = pix.line_end && y_at_max;
  assign busy          = (state_q != ST_IDLE);
  // An abort arriving in DONE cancels the pulse.
  assign done          = (state_q == ST_DONE) && !abort;

endmodule

// File: tb/tb_frame_scan_controller.sv
module tb_frame_scan_controller;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int BC = 2;
`ifdef FRAME_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [XW-1:0] h_max;
  logic [YW-1:0] v_max;
  logic          busy, done;

  frame_scan_controller_if #(.XW(XW), .YW(YW)) pix ();

  frame_scan_controller #(.XW(XW), .YW(YW), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .h_max (h_max),
    .v_max (v_max),
    .busy  (busy),
    .done  (done),
    .pix   (pix.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=scanning 2=blanking 3=finished.
  // The position is a linear pixel index k within the latched raster.
  int m_mode = 0;
  int m_k    = 0;
  int m_bl   = 0;
  int m_h    = 0;
  int m_v    = 0;
  int px_cnt, done_cnt;

  function automatic int mx();
    return m_k % (m_h + 1);
  endfunction
  function automatic int my();
    return m_k / (m_h + 1);
  endfunction

  task automatic step();
    bit e_valid, e_le, e_fe;
    @(negedge clk);
    e_valid = (m_mode == 1);
    e_le    = e_valid && (mx() == m_h);
    e_fe    = e_le && (my() == m_v);
    chk("pix_valid", 32'(pix.pix_valid), 32'(e_valid));
    chk("busy",      32'(busy),          32'(m_mode != 0));
    chk("done",      32'(done),          32'(m_mode == 3 && !abort));
    chk("line_end",  32'(pix.line_end),  32'(e_le));
    chk("frame_end", 32'(pix.frame_end), 32'(e_fe));
    if (e_valid) begin
      chk("pix_x", 32'(pix.pix_x), 32'(mx()));
      chk("pix_y", 32'(pix.pix_y), 32'(my()));
    end
    if (pix.pix_valid && pix.pix_ready) px_cnt++;
    if (done) done_cnt++;
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_k = 0; m_h = 0; m_v = 0; m_bl = 0;
    end else begin
      case (m_mode)
        0: if (start && !abort) begin
             m_h = int'(h_max); m_v = int'(v_max); m_k = 0; m_mode = 1;
           end
        1: if (abort) m_mode = 0;
           else if (pix.pix_ready) begin
             if (e_fe) m_mode = 3;
             else begin
               m_k++;
               if (e_le && BLANK_EN) begin m_mode = 2; m_bl = BC; end
             end
           end
        2: if (abort) m_mode = 0;
           else begin
             m_bl--;
             if (m_bl == 0) m_mode = 1;
           end
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  // Advance until the model is presenting pixel index k (bounded).
  task automatic run_to(input int k, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (m_mode == 1 && m_k == k) hit = 1'b1;
      else step();
    end
    chk(tag, 32'(m_mode * 100 + m_k), 32'(100 + k));
  endtask

  task automatic begin_frame(input int h, input int v);
    h_max = XW'(h); v_max = YW'(v); start = 1'b1;
    step();
    start = 1'b0;
    h_max = XW'($urandom);  // must be ignored while busy
    v_max = YW'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; h_max = '0; v_max = '0;
    pix.pix_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_x", 32'(pix.pix_x), 32'd0);
    chk("rst_y", 32'(pix.pix_y), 32'd0);
    step();

    // Basic 4x2 frame, ready always high.
    pix.pix_ready = 1'b1;
    begin_frame(3, 1);
    px_cnt = 0; done_cnt = 0;
    repeat (14) step();
    chk("frame_pixels", 32'(px_cnt), 32'd8);
    chk("frame_done",   32'(done_cnt), 32'd1);

    // Back-pressure on pixel (2,0).
    begin_frame(3, 1);
    run_to(2, "reach_2_0");
    pix.pix_ready = 1'b0;
    step(); step();
    pix.pix_ready = 1'b1;
    step();
    chk("after_stall_x", 32'(pix.pix_x), 32'd3);
    repeat (12) step();

    // Abort at (1,1) with ready high, then restart.
    begin_frame(3, 1);
    run_to(5, "reach_1_1");
    abort = 1'b1;
    done_cnt = 0;
    step();
    abort = 1'b0;
    repeat (3) step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    begin_frame(3, 1);
    chk("restart_x", 32'(pix.pix_x), 32'd0);
    chk("restart_y", 32'(pix.pix_y), 32'd0);
    repeat (12) step();

    // Single-pixel frame.
    begin_frame(0, 0);
    px_cnt = 0; done_cnt = 0;
    repeat (4) step();
    chk("single_pixels", 32'(px_cnt), 32'd1);
    chk("single_done",   32'(done_cnt), 32'd1);

    // Reset mid-frame at (2,1).
    begin_frame(3, 1);
    run_to(6, "reach_2_1");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_x", 32'(pix.pix_x), 32'd0);
    chk("midrst_y", 32'(pix.pix_y), 32'd0);
    step();

    // Start together with abort in IDLE.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      start         = ($urandom_range(0, 4) == 0);
      abort         = ($urandom_range(0, 49) == 0);
      pix.pix_ready = ($urandom_range(0, 9) < 7);
      h_max         = XW'($urandom_range(0, 3));
      v_max         = YW'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
